// File: rtl/log_pkg.sv
// Shared log-buffer constants for the writer and reader state machines.
// Both FSMs use 2-bit encodings.
package log_pkg;

    typedef logic [1:0] log_state_t;

    localparam log_state_t WR_IDLE  = 2'd0;
    localparam log_state_t WR_FILL  = 2'd1;
    localparam log_state_t WR_FULL  = 2'd2;

    localparam log_state_t RD_IDLE  = 2'd0;
    localparam log_state_t RD_READ  = 2'd1;
    localparam log_state_t RD_LATCH = 2'd2;
    localparam log_state_t RD_SEND  = 2'd3;

endpackage

// File: rtl/log_reader.sv
// Streams the whole log buffer out of a BRAM read port, one word per
// READ/LATCH/SEND round trip, ascending from address 0.
module log_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              log_active,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    import log_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    log_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                cnt_d = '0;
                // log_active only gates the exit from IDLE
                if (start && !log_active) begin
                    state_d = RD_READ;
                end
            end
            RD_READ: begin
                state_d = RD_LATCH;
            end
            RD_LATCH: begin
                data_d  = bram_dout;
                state_d = RD_SEND;
            end
            RD_SEND: begin
                if (m_ready) begin
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = RD_IDLE;
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        state_d = RD_READ;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        bram_en   = (state_q == RD_READ);
        bram_addr = cnt_q;
        m_valid   = (state_q == RD_SEND);
        m_data    = data_q;
        busy      = (state_q != RD_IDLE);
        done      = done_q;
    end

endmodule

// File: tb/tb_log_reader.sv
// Directed bench for log_reader with ADDR_W=2 and a BRAM model
// that returns 0xA000+addr one clock after the read enable.
module tb_log_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        log_active = 1'b0;
    logic        bram_en;
    logic [1:0]  bram_addr;
    logic [15:0] bram_dout = 16'h0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    logic [15:0] words[$];

    log_reader #(.ADDR_W(2), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .log_active(log_active),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) bram_dout <= 16'hA000 + {14'h0, bram_addr};
    end

    // A word is taken at the next rising edge when both are high here.
    always @(negedge clk) begin
        if (m_valid && m_ready) words.push_back(m_data);
        if (done) n_done++;
    end

    typedef struct {
        logic        rst, start, act, rdy;
        logic        ev, een, eb, ed;
        logic [1:0]  ea;
        logic [15:0] edat;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic r, input logic s,
                                input logic ev, input logic een,
                                input logic eb, input logic ed,
                                input logic [1:0] ea,
                                input logic [15:0] edat);
        vec_t v;
        v.rst = r; v.start = s; v.act = 1'b0; v.rdy = 1'b1;
        v.ev = ev; v.een = een; v.eb = eb; v.ed = ed;
        v.ea = ea; v.edat = edat;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; log_active = 1'b0; m_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int max, input string nm);
        for (int i = 0; i < max && done !== 1'b1; i++) step();
        chk(nm, {31'h0, done}, 32'h1);
    endtask

    task automatic chk_words(input int base, input int n, input string nm);
        chk({nm, "_count"}, words.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < words.size())
                chk(nm, {16'h0, words[base+i]}, 32'hA000 + (i % 4));
        end
    endtask

    initial begin
        int qb;
        int db;

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
        tbl[1]  = mk(0, 1, 0, 1, 1, 0, 2'd0, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 2'd0, 16'h0000);
        tbl[3]  = mk(0, 0, 1, 0, 1, 0, 2'd0, 16'hA000);
        tbl[4]  = mk(0, 0, 0, 1, 1, 0, 2'd1, 16'hA000);
        tbl[5]  = mk(0, 0, 0, 0, 1, 0, 2'd1, 16'hA000);
        tbl[6]  = mk(0, 0, 1, 0, 1, 0, 2'd1, 16'hA001);
        tbl[7]  = mk(0, 0, 0, 1, 1, 0, 2'd2, 16'hA001);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 2'd2, 16'hA001);
        tbl[9]  = mk(0, 0, 1, 0, 1, 0, 2'd2, 16'hA002);
        tbl[10] = mk(0, 0, 0, 1, 1, 0, 2'd3, 16'hA002);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 2'd3, 16'hA002);
        tbl[12] = mk(0, 0, 1, 0, 1, 0, 2'd3, 16'hA003);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 2'd0, 16'hA003);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 2'd0, 16'hA003);

        step();
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; start = tbl[i].start;
            log_active = tbl[i].act; m_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), {31'h0, m_valid}, {31'h0, tbl[i].ev});
            chk($sformatf("v%0d_en", i), {31'h0, bram_en}, {31'h0, tbl[i].een});
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].eb});
            chk($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, tbl[i].ed});
            chk($sformatf("v%0d_addr", i), {30'h0, bram_addr}, {30'h0, tbl[i].ea});
            chk($sformatf("v%0d_data", i), {16'h0, m_data}, {16'h0, tbl[i].edat});
        end

        // backpressure on word 1
        do_reset();
        qb = words.size(); db = n_done;
        start = 1'b1; m_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        m_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'h0, m_valid}, 32'h1);
            chk("stall_data", {16'h0, m_data}, 32'hA001);
            step();
        end
        m_ready = 1'b1;
        wait_done(20, "stall_done");
        step();
        chk_words(qb, 4, "stall_word");
        chk("stall_ndone", n_done - db, 1);

        // log_active gate
        do_reset();
        start = 1'b1; log_active = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_busy", {31'h0, busy}, 32'h0);
        end
        log_active = 1'b0;
        step();
        chk("gate_go_busy", {31'h0, busy}, 32'h1);
        chk("gate_go_en", {31'h0, bram_en}, 32'h1);
        start = 1'b0;
        log_active = 1'b1;
        wait_done(20, "gate_done");
        step();

        // reset in SEND of word 2
        do_reset();
        db = n_done;
        start = 1'b1; m_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && !(m_valid && m_data == 16'hA002); i++) step();
        chk("rst_reach_w2", {16'h0, m_data}, 32'hA002);
        m_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_data", {16'h0, m_data}, 32'h0);
        step();
        chk("rst_nodone", n_done - db, 0);
        qb = words.size();
        start = 1'b1; m_ready = 1'b1;
        step();
        start = 1'b0;
        wait_done(20, "rst_redone");
        step();
        chk_words(qb, 4, "rst_word");

        // start held across done
        do_reset();
        qb = words.size(); db = n_done;
        start = 1'b1; m_ready = 1'b1;
        wait_done(20, "hold_done1");
        step();
        chk("hold_restart_busy", {31'h0, busy}, 32'h1);
        chk("hold_restart_en", {31'h0, bram_en}, 32'h1);
        chk("hold_restart_addr", {30'h0, bram_addr}, 32'h0);
        start = 1'b0;
        wait_done(20, "hold_done2");
        step();
        chk_words(qb, 8, "hold_word");
        chk("hold_ndone", n_done - db, 2);

        // start pulsed mid-readout
        do_reset();
        qb = words.size(); db = n_done;
        start = 1'b1; m_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        start = 1'b1;
        step();
        chk("mid_addr", {30'h0, bram_addr}, 32'h1);
        start = 1'b0;
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(20, "mid_done");
        for (int i = 0; i < 4; i++) step();
        chk("mid_idle", {31'h0, busy}, 32'h0);
        chk_words(qb, 4, "mid_word");
        chk("mid_ndone", n_done - db, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
